// File: rtl/reg_port_seq_if.sv
// rtl/reg_port_seq_if.sv - operand request/response and register-file port bundle for reg_port_seq
interface reg_port_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [ADDR_W-1:0] req_rd;
  logic              req_wr_en;
  logic [DATA_W-1:0] req_wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rs1_data;
  logic [DATA_W-1:0] rsp_rs2_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_reg_adress;
  logic [DATA_W-1:0] rf_data_write;
  logic [DATA_W-1:0] rf_data_read;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_wr_en, req_wr_data, rsp_ready, rf_data_read,
    input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, rf_reg_write, rf_reg_adress, rf_data_write
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wr_en, req_wr_data, rsp_ready, rf_data_read,
    output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, rf_reg_write, rf_reg_adress, rf_data_write
  );
endinterface

// File: rtl/reg_port_seq.sv
// rtl/reg_port_seq.sv - serializes rs1/rs2 reads and optional rd write onto a single-port register file
// Optional SPARC %g0 semantics (reads of r0 return 0, writes to r0 dropped) under `define G0_ZERO_EN.
module reg_port_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst,
  reg_port_seq_if.slave bus
);

`ifdef G0_ZERO_EN
  localparam bit G0_ZERO = 1'b1;
`else
  localparam bit G0_ZERO = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD1, RD2, WRC, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              req_ready_q, rsp_valid_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wd;
  logic              accept;
  logic              do_write;
  logic              rs1_zero, rs2_zero;

  assign accept   = bus.req_valid && req_ready_q;
  assign do_write = wr_en_q && !(G0_ZERO && (rd_q == '0));
  assign rs1_zero = G0_ZERO && (rs1_q == '0);
  assign rs2_zero = G0_ZERO && (rs2_q == '0);

  // rf_* depend only on state and latched request fields, never on live req_*/rsp_ready.
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wd     = '0;
    case (state)
      IDLE: if (accept) state_nxt = RD1;
      RD1: begin
        rf_addr   = rs1_q;
        state_nxt = RD2;
      end
      RD2: begin
        rf_addr   = rs2_q;
        state_nxt = WRC;
      end
      WRC: begin
        if (do_write) begin
          rf_we   = 1'b1;
          rf_addr = rd_q;
          rf_wd   = wr_data_q;
        end else begin
          rf_addr = rs2_q;
        end
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      req_ready_q <= (state_nxt == IDLE);
      rsp_valid_q <= (state_nxt == RESP);
      if (accept) begin
        rs1_q     <= bus.req_rs1;
        rs2_q     <= bus.req_rs2;
        rd_q      <= bus.req_rd;
        wr_en_q   <= bus.req_wr_en;
        wr_data_q <= bus.req_wr_data;
      end
      // The file's read port is registered, so each operand lands one state after its address.
      if (state == RD2) rs1_data_q <= rs1_zero ? '0 : bus.rf_data_read;
      if (state == WRC) rs2_data_q <= rs2_zero ? '0 : bus.rf_data_read;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rs1_data  = rs1_data_q;
  assign bus.rsp_rs2_data  = rs2_data_q;
  assign bus.rf_reg_write  = rf_we;
  assign bus.rf_reg_adress = rf_addr;
  assign bus.rf_data_write = rf_wd;

endmodule

// File: tb/tb_reg_port_seq.sv
// tb/tb_reg_port_seq.sv - directed table-driven bench for reg_port_seq with a registered-read register file model
module tb_reg_port_seq;

`ifdef G0_ZERO_EN
  localparam bit G0 = 1'b1;
`else
  localparam bit G0 = 1'b0;
`endif

  logic clk;
  logic rst;
  logic mem_init;
  logic [31:0] mem [32];
  int errors;
  int checks;
  int wr_pulses;

  reg_port_seq_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_port_seq #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port register file: a write cycle leaves data_read holding its previous value.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem[7] <= 32'h0000_0011;
    end else if (bus.rf_reg_write) begin
      mem[bus.rf_reg_adress] <= bus.rf_data_write;
      wr_pulses = wr_pulses + 1;
    end else begin
      bus.rf_data_read <= mem[bus.rf_reg_adress];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request; returns both operands, edges from accept to rsp_valid, and a busy-ready flag.
  task automatic do_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wr_en, input logic [31:0] wd,
                        output logic [31:0] d1, output logic [31:0] d2,
                        output int lat, output logic busy_ready);
    int guard;
    bus.req_valid   = 1'b1;
    bus.req_rs1     = rs1;
    bus.req_rs2     = rs2;
    bus.req_rd      = rd;
    bus.req_wr_en   = wr_en;
    bus.req_wr_data = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    lat = 0;
    busy_ready = 1'b0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.req_ready) busy_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    d1 = bus.rsp_rs1_data;
    d2 = bus.rsp_rs2_data;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        wr_en;
    logic [31:0] wd, e1, e2;
  } vec_t;

  vec_t vt [10];
  logic [31:0] d1, d2;
  int lat, p0;
  logic busy;

  initial begin
    errors = 0; checks = 0; wr_pulses = 0;
    rst = 1'b1; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0;
    bus.req_wr_en = 1'b0; bus.req_wr_data = '0; bus.rsp_ready = 1'b1;

    vt[0] = '{5'd1,  5'd2,  5'd5,  1'b1, 32'hDEAD_BEEF, 32'hA000_0001, 32'hA000_0002};
    vt[1] = '{5'd5,  5'd6,  5'd0,  1'b0, 32'h0,         32'hDEAD_BEEF, 32'hA000_0006};
    vt[2] = '{5'd7,  5'd7,  5'd7,  1'b1, 32'h22,        32'h11,        32'h11};
    vt[3] = '{5'd7,  5'd5,  5'd0,  1'b0, 32'h0,         32'h22,        32'hDEAD_BEEF};
    vt[4] = '{5'd3,  5'd4,  5'd3,  1'b0, 32'h99,        32'hA000_0003, 32'hA000_0004};
    vt[5] = '{5'd3,  5'd3,  5'd0,  1'b0, 32'h0,         32'hA000_0003, 32'hA000_0003};
    vt[6] = '{5'd31, 5'd30, 5'd31, 1'b1, 32'h1234_5678, 32'hA000_001F, 32'hA000_001E};
    vt[7] = '{5'd31, 5'd0,  5'd0,  1'b0, 32'h0,         32'h1234_5678, G0 ? 32'h0 : 32'hA000_0000};
    vt[8] = '{5'd1,  5'd2,  5'd0,  1'b1, 32'h55,        32'hA000_0001, 32'hA000_0002};
    vt[9] = '{5'd0,  5'd0,  5'd0,  1'b0, 32'h0,         G0 ? 32'h0 : 32'h55, G0 ? 32'h0 : 32'h55};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rs1_data", bus.rsp_rs1_data, 32'd0);
    check("rst_rs2_data", bus.rsp_rs2_data, 32'd0);
    check("rst_rf_write", 32'(bus.rf_reg_write), 32'd0);
    check("rst_rf_addr", 32'(bus.rf_reg_adress), 32'd0);
    check("rst_rf_wdata", bus.rf_data_write, 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      p0 = wr_pulses;
      do_req(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wr_en, vt[i].wd, d1, d2, lat, busy);
      check($sformatf("v%0d_rs1", i), d1, vt[i].e1);
      check($sformatf("v%0d_rs2", i), d2, vt[i].e2);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_busy_ready", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_wr_pulses", i), 32'(wr_pulses - p0),
            (vt[i].wr_en && !(G0 && vt[i].rd == 5'd0)) ? 32'd1 : 32'd0);
    end

    // Back-pressure: response must hold with no file activity.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_req(5'd5, 5'd7, 5'd7, 1'b0, 32'h0, d1, d2, lat, busy);
    check("bp_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp%0d_rf_write", c), 32'(bus.rf_reg_write), 32'd0);
      check($sformatf("bp%0d_rs1", c), bus.rsp_rs1_data, 32'hDEAD_BEEF);
      check($sformatf("bp%0d_rs2", c), bus.rsp_rs2_data, 32'h22);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset during RD2.
    bus.req_valid = 1'b1; bus.req_rs1 = 5'd1; bus.req_rs2 = 5'd2; bus.req_wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rd2_addr_rs2", 32'(bus.rf_reg_adress), 32'd2);
    rst = 1'b1;
    #1;
    check("rd2_rst_rf_write", 32'(bus.rf_reg_write), 32'd0);
    check("rd2_rst_rf_addr", 32'(bus.rf_reg_adress), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rd2_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rd2_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd2_rst_rs1_data", bus.rsp_rs1_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset with a write pending in WRC: pulse drops asynchronously, write abandoned.
    bus.req_valid = 1'b1; bus.req_rs1 = 5'd9; bus.req_rs2 = 5'd9; bus.req_rd = 5'd9;
    bus.req_wr_en = 1'b1; bus.req_wr_data = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrc_pending_write", 32'(bus.rf_reg_write), 32'd1);
    p0 = wr_pulses;
    rst = 1'b1;
    #1;
    check("wrc_rst_rf_write", 32'(bus.rf_reg_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(5'd9, 5'd8, 5'd0, 1'b0, 32'h0, d1, d2, lat, busy);
    check("wrc_abandoned_pulses", 32'(wr_pulses - p0), 32'd0);
    check("wrc_abandoned_rs1", d1, 32'hA000_0009);
    check("wrc_abandoned_rs2", d2, 32'hA000_0008);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
